// File: rtl/seq_mul4.sv
// seq_mul4: sequential 4x4 unsigned shift-add multiplier.
// Each iteration hands A and (Q[0] ? M : 0) to the external 4-bit adder and
// shifts {carry, sum, Q} right by one. After ITER iterations {A,Q} is the product.
module seq_mul4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ITER  = 4
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   add_x,
    output logic [WIDTH-1:0]   add_y,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_result,
    input  logic               add_cf,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2:0]         count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               zero_q, zero_d;

    // {A,Q} after this iteration's add and right shift
    logic [2*WIDTH-1:0] shifted;

    // Adder operands come straight from registers; carry-in fixed for add mode
    always_comb begin
        add_x   = acc_q;
        add_y   = mq_q[0] ? mcand_q : '0;
        add_cin = 1'b0;
        shifted = {add_cf, add_result, mq_q[WIDTH-1:1]};
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;
        zero_d    = zero_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mq_d    = b;
                    mcand_d = a;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = shifted[2*WIDTH-1:WIDTH];
                mq_d    = shifted[WIDTH-1:0];
                count_d = count_q + 3'd1;
                if (count_q == 3'(ITER - 1)) begin
                    product_d = shifted;
                    zero_d    = (shifted == '0);
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
            zero_q    <= zero_d;
        end
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        product = product_q;
        zero    = zero_q;
    end

endmodule

// File: tb/tb_seq_mul4.sv
// Testbench for seq_mul4: models the external 4-bit adder and scoreboards products.
module tb_seq_mul4;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] add_x, add_y, add_result;
    logic       add_cin, add_cf;
    logic       busy, done, zero;
    logic [7:0] product;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];

    // Operation-level observations
    int   lat;
    int   busy_cycles;
    logic cf_seen;
    logic y_nonzero;
    logic cin_bad;

    seq_mul4 #(.WIDTH(4), .ITER(4)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .start      (start),
        .a          (a),
        .b          (b),
        .add_x      (add_x),
        .add_y      (add_y),
        .add_cin    (add_cin),
        .add_result (add_result),
        .add_cf     (add_cf),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .zero       (zero)
    );

    // External adder model
    assign {add_cf, add_result} = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard and compare against the DUT result
    task automatic score(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_product"}, {8'h0, product}, {8'h0, e});
            chk({tag, "_zero"}, {15'h0, zero}, {15'h0, (e == 8'h00)});
        end
    endtask

    // Accept one operation and follow it to done (bounded), recording adder activity
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input string tag);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(8'(av * bv));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av;
        b = ~bv;
        lat = 0;
        busy_cycles = 0;
        cf_seen = 1'b0;
        y_nonzero = 1'b0;
        cin_bad = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (add_cin !== 1'b0) cin_bad = 1'b1;
            if (busy && !done) begin
                if (add_cf) cf_seen = 1'b1;
                if (add_y != 4'h0) y_nonzero = 1'b1;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            chk({tag, "_timeout"}, 16'd0, 16'd1);
            void'(exp_q.pop_front());
        end else begin
            chk({tag, "_latency"}, 16'(lat), 16'd5);
            chk({tag, "_busy_cycles"}, 16'(busy_cycles), 16'd5);
            chk({tag, "_cin"}, {15'h0, cin_bad}, 16'd0);
            score(tag);
        end
    endtask

    initial begin
        int dones;
        int last_done;
        logic prev_done;

        // Reset state
        clrn = 1'b0;
        #12;
        chk("rst_product", {8'h0, product}, 16'h0000);
        chk("rst_zero", {15'h0, zero}, 16'd1);
        chk("rst_busy", {15'h0, busy}, 16'd0);
        chk("rst_done", {15'h0, done}, 16'd0);
        chk("rst_add_y", {12'h0, add_y}, 16'h0);
        chk("rst_add_x", {12'h0, add_x}, 16'h0);
        @(negedge clk);
        clrn = 1'b1;

        // 13 * 11 = 143
        run_op(4'd13, 4'd11, "m13x11");
        chk("m13x11_prod_const", {8'h0, product}, 16'h008F);

        // 15 * 15 exercises the carry path
        run_op(4'd15, 4'd15, "m15x15");
        chk("m15x15_cf_seen", {15'h0, cf_seen}, 16'd1);

        // Zero operands
        run_op(4'd0, 4'd9, "m0x9");
        run_op(4'd7, 4'd0, "m7x0");
        chk("m7x0_add_y_zero", {15'h0, y_nonzero}, 16'd0);

        // Start pulses during CALC and DONE are ignored
        @(negedge clk);
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        exp_q.push_back(8'h0F);
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                score("ign");
            end
            start = 1'b0;
            if (k == 2 || k == 5) begin
                a = 4'd9;
                b = 4'd9;
                start = 1'b1;
            end
        end
        chk("ign_done_count", 16'(dones), 16'd1);
        chk("ign_idle_after", {15'h0, busy}, 16'd0);
        chk("ign_product_held", {8'h0, product}, 16'h000F);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        a = 4'd12;
        b = 4'd12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {15'h0, busy}, 16'd1);
        #1;
        clrn = 1'b0;
        #1;
        chk("abort_busy", {15'h0, busy}, 16'd0);
        chk("abort_product", {8'h0, product}, 16'h0000);
        chk("abort_zero", {15'h0, zero}, 16'd1);
        chk("abort_done", {15'h0, done}, 16'd0);
        @(negedge clk);
        clrn = 1'b1;
        run_op(4'd6, 4'd7, "m6x7");
        chk("m6x7_prod_const", {8'h0, product}, 16'h002A);

        // Start held high: back-to-back operations every 6 cycles
        @(negedge clk);
        a = 4'd2;
        b = 4'd3;
        start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h06);
        dones = 0;
        last_done = -1;
        prev_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                chk("hold_no_consec", {15'h0, prev_done}, 16'd0);
                if (last_done >= 0) chk("hold_interval", 16'(k - last_done), 16'd6);
                last_done = k;
                dones++;
                score("hold");
                if (dones == 3) begin
                    start = 1'b0;
                    break;
                end
            end
            prev_done = done;
        end
        start = 1'b0;
        chk("hold_done_count", 16'(dones), 16'd3);
        @(negedge clk);
        @(negedge clk);
        chk("hold_idle_after", {15'h0, busy}, 16'd0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
